// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle for the bit-serial add/subtract sequencer.
// The requester owns start/sub/a/b and the sequencer owns the status and result.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             zero;

   modport master (
      output start, sub, a, b,
      input  ready, busy, done, result, carry_out, overflow, zero
   );

   modport slave (
      input  start, sub, a, b,
      output ready, busy, done, result, carry_out, overflow, zero
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer driving one external 1-bit full adder,
// LSB first. It keeps the carry between bits and shifts the sum into result.
module serial_add_ctrl #(
   parameter  int WIDTH = 64,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   serial_add_ctrl_if.slave   bus,
   output logic               fa_a,
   output logic               fa_b,
   output logic               fa_cin,
   input  logic               fa_sum,
   input  logic               fa_cout
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             carry_q, carry_d;
   logic             carry_out_q, carry_out_d;
   logic             overflow_q, overflow_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             run;
   logic             last_bit;

   assign run      = (state_q == RUN);
   assign last_bit = (count_q == CNT_W'(WIDTH - 1));

   // Adder inputs are forced low outside RUN so the shared adder sees quiet inputs.
   assign fa_a   = run & a_sh_q[0];
   assign fa_b   = run & b_sh_q[0];
   assign fa_cin = run & carry_q;

   always_comb begin
      state_d     = state_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      result_d    = result_q;
      count_d     = count_q;
      carry_d     = carry_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      ready_d     = ready_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            if (bus.start) begin
               // Subtract is A + ~B + 1: invert B here, seed carry with sub.
               state_d = RUN;
               a_sh_d  = bus.a;
               b_sh_d  = bus.b ^ {WIDTH{bus.sub}};
               carry_d = bus.sub;
               count_d = '0;
               ready_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            result_d = {fa_sum, result_q[WIDTH-1:1]};
            carry_d  = fa_cout;
            count_d  = count_q + CNT_W'(1);
            if (last_bit) begin
               state_d     = DONE;
               overflow_d  = carry_q ^ fa_cout;
               carry_out_d = fa_cout;
               ready_d     = 1'b1;
               busy_d      = 1'b0;
               done_d      = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         result_q    <= '0;
         count_q     <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         result_q    <= result_d;
         count_q     <= count_d;
         carry_q     <= carry_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.ready     = ready_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;
   assign bus.zero      = (result_q == '0);

endmodule
